// File: rtl/mac_pkg.sv
// Shared definitions for the FP16 MAC pipeline scheduler.
package mac_pkg;

  localparam int FP16_W         = 16;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_PIPE_DEPTH = 5;
  localparam int DEF_MAX_OUT    = 2;

  // Width needed to index n items; never narrower than one bit.
  function automatic int tag_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rsp_fifo.sv
// Per-requester result FIFO. The scheduler's credit accounting guarantees
// space for every push; a push into a full FIFO without a same-cycle pop
// raises an assertion and the data is not written.
module rsp_fifo
  import mac_pkg::*;
#(
  parameter  int DEPTH = DEF_MAX_OUT,
  localparam int CNT_W = tag_width(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [FP16_W-1:0] push_data,
  input  logic              pop,
  output logic [FP16_W-1:0] head_data,
  output logic [CNT_W-1:0]  count,
  output logic              not_empty
);

  localparam int PTR_W = tag_width(DEPTH);

  logic [FP16_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              pop_ok;
  logic              push_ok;

  assign pop_ok    = pop && (count != '0);
  assign push_ok   = push && ((count != CNT_W'(DEPTH)) || pop_ok);
  assign not_empty = (count != '0);
  assign head_data = mem[rd_ptr];

  // Storage, pointers and occupancy; simultaneous push and pop keep the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop_ok)
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // An overflowing push means the credit accounting upstream is broken.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop_ok && (count == CNT_W'(DEPTH))))
    else $error("rsp_fifo push while full");

endmodule

// File: rtl/mac_pipe_scheduler.sv
// Round-robin scheduler sharing one FP16 MAC pipeline between NUM_REQ
// requesters, with per-requester credit limits and result FIFOs.
// Optional build macro MAC_SCHED_PRIO0_EN: requester 0 takes strict priority
// whenever eligible; the rest share round-robin and a requester-0 grant does
// not move the round-robin pointer.
module mac_pipe_scheduler
  import mac_pkg::*;
#(
  parameter  int NUM_REQ    = DEF_NUM_REQ,
  parameter  int PIPE_DEPTH = DEF_PIPE_DEPTH,
  parameter  int MAX_OUT    = DEF_MAX_OUT,
  localparam int TAG_W      = tag_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*FP16_W-1:0] req_a,
  input  logic [NUM_REQ*FP16_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      issue_valid,
  output logic [FP16_W-1:0]         issue_a,
  output logic [FP16_W-1:0]         issue_b,
  output logic [TAG_W-1:0]          issue_tag,
  input  logic [FP16_W-1:0]         mac_result,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [NUM_REQ*FP16_W-1:0] rsp_data,
  input  logic [NUM_REQ-1:0]        rsp_ready
);

  localparam int CRED_W = tag_width(MAX_OUT + 1);

  logic [TAG_W-1:0]  rr_ptr;
  logic [CRED_W-1:0] credit   [NUM_REQ];
  logic [CRED_W-1:0] fifo_cnt [NUM_REQ];
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant_vec;
  logic [NUM_REQ-1:0] pop;
  logic [NUM_REQ-1:0] push_vec;
  logic               grant_any;
  logic [TAG_W-1:0]   grant_idx;
  logic               rr_update;
  logic               pipe_vld [PIPE_DEPTH];
  logic [TAG_W-1:0]   pipe_tag [PIPE_DEPTH];

  // A requester may be granted only while it holds a free credit.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++)
      eligible[i] = req_valid[i] && (credit[i] < CRED_W'(MAX_OUT));
  end

  // Arbiter: pick the first eligible requester after rr_ptr.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
`ifdef MAC_SCHED_PRIO0_EN
    if (eligible[0]) begin
      grant_any = 1'b1;
    end else
`endif
    begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (int'(rr_ptr) + k) % NUM_REQ;
        if (!grant_any && eligible[idx]) begin
          grant_any = 1'b1;
          grant_idx = TAG_W'(idx);
        end
      end
    end
    grant_vec = '0;
    grant_vec[grant_idx] = grant_any;
`ifdef MAC_SCHED_PRIO0_EN
    rr_update = grant_any && (grant_idx != '0);
`else
    rr_update = grant_any;
`endif
  end

  // No grant is visible while reset is held, even with requests pending.
  assign req_ready = rst ? '0 : grant_vec;
  assign pop       = rsp_valid & rsp_ready;

  // Round-robin pointer; reset parks it on the last requester so 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            rr_ptr <= TAG_W'(NUM_REQ - 1);
    else if (rr_update) rr_ptr <= grant_idx;
  end

  // Issue register: operands and tag of the winner, held when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_valid <= 1'b0;
      issue_a     <= '0;
      issue_b     <= '0;
      issue_tag   <= '0;
    end else begin
      issue_valid <= grant_any;
      if (grant_any) begin
        issue_a   <= req_a[int'(grant_idx)*FP16_W +: FP16_W];
        issue_b   <= req_b[int'(grant_idx)*FP16_W +: FP16_W];
        issue_tag <= grant_idx;
      end
    end
  end

  // Tag pipe tracks each issue until its result leaves the MAC pipeline;
  // clearing it on reset drops results of operations issued before reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        pipe_vld[k] <= 1'b0;
        pipe_tag[k] <= '0;
      end
    end else begin
      pipe_vld[0] <= issue_valid;
      pipe_tag[0] <= issue_tag;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        pipe_tag[k] <= pipe_tag[k-1];
      end
    end
  end

  // Route the emerging result to its owner's FIFO.
  always_comb begin
    push_vec = '0;
    for (int i = 0; i < NUM_REQ; i++)
      push_vec[i] = pipe_vld[PIPE_DEPTH-1] && (pipe_tag[PIPE_DEPTH-1] == TAG_W'(i));
  end

  // Credits count in-flight plus buffered results per requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) credit[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        case ({grant_vec[i], pop[i]})
          2'b10:   credit[i] <= credit[i] + CRED_W'(1);
          2'b01:   credit[i] <= credit[i] - CRED_W'(1);
          default: credit[i] <= credit[i];
        endcase
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
    rsp_fifo #(.DEPTH(MAX_OUT)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_vec[i]),
      .push_data (mac_result),
      .pop       (pop[i]),
      .head_data (rsp_data[i*FP16_W +: FP16_W]),
      .count     (fifo_cnt[i]),
      .not_empty (rsp_valid[i])
    );

    // Buffered results are always a subset of the outstanding credits.
    a_cnt_le_credit: assert property (@(posedge clk) disable iff (rst)
      fifo_cnt[i] <= credit[i])
      else $error("fifo occupancy exceeds credit");
  end

endmodule

// File: tb/tb_mac_pipe_scheduler.sv
// Self-checking bench for mac_pipe_scheduler (default parameters).
module tb_mac_pipe_scheduler;
  import mac_pkg::*;

  localparam int NR = 4;
  localparam int PD = 5;
  localparam int MO = 2;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic        issue_valid;
  logic [15:0] issue_a, issue_b;
  logic [1:0]  issue_tag;
  logic [15:0] mac_result;
  logic [3:0]  rsp_valid;
  logic [63:0] rsp_data;
  logic [3:0]  rsp_ready;

  mac_pipe_scheduler dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .issue_valid(issue_valid), .issue_a(issue_a),
    .issue_b(issue_b), .issue_tag(issue_tag), .mac_result(mac_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: outstanding operations and per-requester result queues.
  typedef struct {
    int          due;
    int          tag;
    logic [15:0] val;
  } flight_t;

  flight_t     infl[$];
  logic [15:0] mq [NR][$];
  int          mrr, cyc, mgrant;
  logic [3:0]  cur_v, cur_rr;
  logic [15:0] cur_ga, cur_gb;
  logic        exp_iv;
  logic [1:0]  exp_tag;
  logic [15:0] exp_ia, exp_ib;
  logic [3:0]  exp_ready, exp_rv;
  logic [63:0] exp_data, data_mask;
  int          checks, errors;

  // Stand-in for the MAC: exact for a unit operand, arbitrary mixing otherwise.
  function automatic logic [15:0] mac_model(input logic [15:0] a, input logic [15:0] b);
    if (a == 16'h3C00) return b;
    if (b == 16'h3C00) return a;
    return a ^ {b[14:0], b[15]} ^ 16'h5A3C;
  endfunction

  function automatic int outstanding(input int r);
    int n;
    n = mq[r].size();
    foreach (infl[k]) if (infl[k].tag == r) n++;
    return n;
  endfunction

  task automatic model_reset();
    infl.delete();
    for (int i = 0; i < NR; i++) mq[i].delete();
    mrr = NR - 1;
    exp_iv = 1'b0; exp_tag = '0; exp_ia = '0; exp_ib = '0;
  endtask

  // Apply one cycle of inputs at the falling edge and form expectations.
  task automatic drive(input logic [3:0] v, input logic [3:0] rr, input bit fixed0 = 1'b0);
    int idx;
    @(negedge clk);
    req_valid = v;
    rsp_ready = rr;
    for (int i = 0; i < NR; i++) begin
      req_a[16*i +: 16] = 16'($urandom);
      req_b[16*i +: 16] = 16'($urandom);
    end
    if (fixed0) begin
      req_a[15:0] = 16'h3C00;
      req_b[15:0] = 16'h4000;
    end
    mac_result = 16'($urandom);
    foreach (infl[k]) if (infl[k].due == cyc) mac_result = infl[k].val;
    #1;
    mgrant = -1;
`ifdef MAC_SCHED_PRIO0_EN
    if (v[0] && outstanding(0) < MO) mgrant = 0;
`endif
    for (int k = 1; k <= NR; k++) begin
      idx = (mrr + k) % NR;
      if (mgrant < 0 && v[idx] && outstanding(idx) < MO) mgrant = idx;
    end
    exp_ready = '0;
    if (mgrant >= 0) exp_ready[mgrant] = 1'b1;
    exp_rv = '0; exp_data = '0; data_mask = '0;
    for (int i = 0; i < NR; i++) begin
      if (mq[i].size() > 0) begin
        exp_rv[i] = 1'b1;
        exp_data[16*i +: 16] = mq[i][0];
        data_mask[16*i +: 16] = 16'hFFFF;
      end
    end
    cur_v = v; cur_rr = rr;
    if (mgrant >= 0) begin
      cur_ga = req_a[16*mgrant +: 16];
      cur_gb = req_b[16*mgrant +: 16];
    end
  endtask

  // Cross the rising edge and advance the model by one cycle.
  task automatic advance();
    @(posedge clk);
    for (int i = 0; i < NR; i++)
      if (cur_rr[i] && mq[i].size() > 0) void'(mq[i].pop_front());
    while (infl.size() > 0 && infl[0].due == cyc) begin
      mq[infl[0].tag].push_back(infl[0].val);
      void'(infl.pop_front());
    end
    if (mgrant >= 0) begin
`ifdef MAC_SCHED_PRIO0_EN
      if (mgrant != 0) mrr = mgrant;
`else
      mrr = mgrant;
`endif
      exp_iv = 1'b1; exp_tag = 2'(mgrant); exp_ia = cur_ga; exp_ib = cur_gb;
      infl.push_back('{due: cyc + 1 + PD, tag: mgrant, val: mac_model(cur_ga, cur_gb)});
    end else begin
      exp_iv = 1'b0;
    end
    cyc++;
  endtask

  task automatic drain();
    for (int k = 0; k < PD + 6; k++) begin
      drive(4'h0, 4'hF);
      advance();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    req_valid = 4'hF; rsp_ready = 4'hF; mac_result = 16'hBEEF;
    req_a = {4{16'h1234}}; req_b = {4{16'h4321}};
    #1;
    checks++;
    if (req_ready !== 4'h0) begin
      errors++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready);
    end
    checks++;
    if ({issue_valid, issue_tag, issue_a, issue_b} !== 35'd0) begin
      errors++; $display("FAIL reset_issue got=%b/%0d/%h/%h exp=0/0/0000/0000",
                         issue_valid, issue_tag, issue_a, issue_b);
    end
    checks++;
    if (rsp_valid !== 4'h0) begin
      errors++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid);
    end
    checks++;
    if (rsp_data !== 64'd0) begin
      errors++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data);
    end
    @(negedge clk);
    rst = 1'b0; req_valid = 4'h0; rsp_ready = 4'h0;
    model_reset();
  endtask

  task automatic test_single();
    int first_rsp;
    first_rsp = -1;
    for (int k = 0; k < 20; k++) begin
      drive((k == 0) ? 4'h1 : 4'h0, 4'h0, k == 0);
      checks++;
      if (req_ready !== exp_ready) begin
        errors++; $display("FAIL single_ready k=%0d got=%b exp=%b", k, req_ready, exp_ready);
      end
      checks++;
      if ({issue_valid, issue_tag, issue_a, issue_b} !== {exp_iv, exp_tag, exp_ia, exp_ib}) begin
        errors++; $display("FAIL single_issue k=%0d got=%b/%0d/%h/%h exp=%b/%0d/%h/%h", k,
                           issue_valid, issue_tag, issue_a, issue_b, exp_iv, exp_tag, exp_ia, exp_ib);
      end
      checks++;
      if (rsp_valid !== exp_rv || (rsp_data & data_mask) !== exp_data) begin
        errors++; $display("FAIL single_rsp k=%0d got=%b/%h exp=%b/%h", k,
                           rsp_valid, rsp_data & data_mask, exp_rv, exp_data);
      end
      if (k == 1) begin
        checks++;
        if (issue_valid !== 1'b1 || issue_tag !== 2'd0) begin
          errors++; $display("FAIL single_issue_cycle got=%b/%0d exp=1/0", issue_valid, issue_tag);
        end
      end
      if (first_rsp < 0 && rsp_valid[0] === 1'b1) begin
        first_rsp = k;
        checks++;
        if (rsp_data[15:0] !== 16'h4000) begin
          errors++; $display("FAIL single_result got=%h exp=4000", rsp_data[15:0]);
        end
      end
      advance();
    end
    checks++;
    if (first_rsp != PD + 2) begin
      errors++; $display("FAIL single_latency got=%0d exp=%0d", first_rsp, PD + 2);
    end
    drain();
  endtask

  task automatic test_all_valid();
    for (int k = 0; k < 40; k++) begin
      drive(4'hF, 4'hF);
      checks++;
      if (req_ready !== exp_ready) begin
        errors++; $display("FAIL allv_ready k=%0d got=%b exp=%b", k, req_ready, exp_ready);
      end
      checks++;
      if ({issue_valid, issue_tag, issue_a, issue_b} !== {exp_iv, exp_tag, exp_ia, exp_ib}) begin
        errors++; $display("FAIL allv_issue k=%0d got=%b/%0d/%h/%h exp=%b/%0d/%h/%h", k,
                           issue_valid, issue_tag, issue_a, issue_b, exp_iv, exp_tag, exp_ia, exp_ib);
      end
      checks++;
      if (rsp_valid !== exp_rv || (rsp_data & data_mask) !== exp_data) begin
        errors++; $display("FAIL allv_rsp k=%0d got=%b/%h exp=%b/%h", k,
                           rsp_valid, rsp_data & data_mask, exp_rv, exp_data);
      end
      if (k >= 1) begin
        checks++;
        if (issue_valid !== 1'b1) begin
          errors++; $display("FAIL allv_throughput k=%0d got=%b exp=1", k, issue_valid);
        end
      end
      advance();
    end
    drain();
  endtask

  task automatic test_credit();
    for (int k = 0; k < 16; k++) begin
      drive(4'h4, (k == 12) ? 4'h4 : 4'h0);
      checks++;
      if (req_ready !== exp_ready) begin
        errors++; $display("FAIL credit_ready k=%0d got=%b exp=%b", k, req_ready, exp_ready);
      end
      checks++;
      if ({issue_valid, issue_tag, issue_a, issue_b} !== {exp_iv, exp_tag, exp_ia, exp_ib}) begin
        errors++; $display("FAIL credit_issue k=%0d got=%b/%0d/%h/%h exp=%b/%0d/%h/%h", k,
                           issue_valid, issue_tag, issue_a, issue_b, exp_iv, exp_tag, exp_ia, exp_ib);
      end
      checks++;
      if (rsp_valid !== exp_rv || (rsp_data & data_mask) !== exp_data) begin
        errors++; $display("FAIL credit_rsp k=%0d got=%b/%h exp=%b/%h", k,
                           rsp_valid, rsp_data & data_mask, exp_rv, exp_data);
      end
      if (k >= 2 && k <= 12) begin
        checks++;
        if (req_ready[2] !== 1'b0) begin
          errors++; $display("FAIL credit_block k=%0d got=%b exp=0", k, req_ready[2]);
        end
      end
      if (k == 13) begin
        checks++;
        if (req_ready !== 4'b0100) begin
          errors++; $display("FAIL credit_regrant got=%b exp=0100", req_ready);
        end
      end
      advance();
    end
    drain();
  endtask

  task automatic test_same_cycle();
    for (int k = 0; k < 22; k++) begin
      // k=0 grant; k=9 grant+pop with credit 1; k=10 grant; k=11 blocked.
      drive((k == 0 || (k >= 9 && k <= 11)) ? 4'h2 : 4'h0, (k == 9 || k >= 12) ? 4'h2 : 4'h0);
      checks++;
      if (req_ready !== exp_ready) begin
        errors++; $display("FAIL same_ready k=%0d got=%b exp=%b", k, req_ready, exp_ready);
      end
      checks++;
      if ({issue_valid, issue_tag, issue_a, issue_b} !== {exp_iv, exp_tag, exp_ia, exp_ib}) begin
        errors++; $display("FAIL same_issue k=%0d got=%b/%0d/%h/%h exp=%b/%0d/%h/%h", k,
                           issue_valid, issue_tag, issue_a, issue_b, exp_iv, exp_tag, exp_ia, exp_ib);
      end
      checks++;
      if (rsp_valid !== exp_rv || (rsp_data & data_mask) !== exp_data) begin
        errors++; $display("FAIL same_rsp k=%0d got=%b/%h exp=%b/%h", k,
                           rsp_valid, rsp_data & data_mask, exp_rv, exp_data);
      end
      if (k == 10 || k == 11) begin
        checks++;
        if (req_ready !== ((k == 10) ? 4'b0010 : 4'b0000)) begin
          errors++; $display("FAIL same_credit k=%0d got=%b", k, req_ready);
        end
      end
      advance();
    end
    drain();
  endtask

  task automatic test_reset_inflight();
    for (int k = 0; k < 3; k++) begin
      drive(4'hF, 4'h0);
      advance();
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, rsp_valid, issue_valid, issue_tag, issue_a, issue_b} !== 43'd0 ||
        rsp_data !== 64'd0) begin
      errors++; $display("FAIL rst_flight_outputs got=%b/%b/%b/%0d/%h/%h/%h", req_ready, rsp_valid,
                         issue_valid, issue_tag, issue_a, issue_b, rsp_data);
    end
    @(negedge clk);
    rst = 1'b0; req_valid = 4'h0; rsp_ready = 4'h0;
    model_reset();
    for (int k = 0; k < PD + 4; k++) begin
      drive(4'h0, 4'h0);
      checks++;
      if (rsp_valid !== 4'h0 || issue_valid !== 1'b0) begin
        errors++; $display("FAIL rst_flight_discard k=%0d got=%b/%b exp=0000/0", k, rsp_valid, issue_valid);
      end
      advance();
    end
    drive(4'hF, 4'h0);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL rst_flight_first got=%b exp=0001", req_ready);
    end
    advance();
    drain();
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      drive(4'($urandom), 4'($urandom));
      checks++;
      if (req_ready !== exp_ready) begin
        errors++; $display("FAIL rand_ready k=%0d got=%b exp=%b", k, req_ready, exp_ready);
      end
      checks++;
      if ({issue_valid, issue_tag, issue_a, issue_b} !== {exp_iv, exp_tag, exp_ia, exp_ib}) begin
        errors++; $display("FAIL rand_issue k=%0d got=%b/%0d/%h/%h exp=%b/%0d/%h/%h", k,
                           issue_valid, issue_tag, issue_a, issue_b, exp_iv, exp_tag, exp_ia, exp_ib);
      end
      checks++;
      if (rsp_valid !== exp_rv || (rsp_data & data_mask) !== exp_data) begin
        errors++; $display("FAIL rand_rsp k=%0d got=%b/%h exp=%b/%h", k,
                           rsp_valid, rsp_data & data_mask, exp_rv, exp_data);
      end
      advance();
    end
    drain();
  endtask

`ifdef MAC_SCHED_PRIO0_EN
  task automatic test_prio0();
    for (int k = 0; k < 4; k++) begin
      drive(4'b1001, 4'h0);
      checks++;
      if (req_ready !== exp_ready) begin
        errors++; $display("FAIL prio_ready k=%0d got=%b exp=%b", k, req_ready, exp_ready);
      end
      checks++;
      if (req_ready !== ((k < 2) ? 4'b0001 : (k == 2) ? 4'b1000 : 4'b1000)) begin
        errors++; $display("FAIL prio_order k=%0d got=%b", k, req_ready);
      end
      advance();
    end
    drain();
  endtask
`endif

  initial begin
    checks = 0; errors = 0; cyc = 0; mgrant = -1;
    rst = 1'b1;
    req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0; mac_result = '0;
    model_reset();
    test_reset();
    test_single();
    test_all_valid();
    test_credit();
    test_same_cycle();
    test_reset_inflight();
    test_random();
`ifdef MAC_SCHED_PRIO0_EN
    test_prio0();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
